// File: rtl/skew_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skew_buf_pkg
// Description : Shared types and width helpers for the skew shift buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package skew_buf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Slot index width; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width must be able to represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : skew_buf_pkg
`default_nettype wire

// File: rtl/valid_popcount.sv
`default_nettype none
// ============================================================================
// Module      : valid_popcount
// Description : Counts the set bits of the slot valid vector.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_popcount #(
    parameter int DEPTH = 7,
    parameter int CNT_W = 3
) (
    input  logic [DEPTH-1:0] valid,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CNT_W'(valid[k]);
        end
    end

endmodule : valid_popcount
`default_nettype wire

// File: rtl/skew_shift_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skew_shift_buffer
// Description : Load/shift operand buffer feeding one systolic-array edge,
//               with per-slot valid bits, occupancy flags and drain mode.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_shift_buffer
    import skew_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int IDX_W  = idx_width(DEPTH),
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [IDX_W-1:0]        load_idx,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    par_load,
    input  logic [DEPTH*DATA_W-1:0] par_data,
    input  logic                    shift,
    input  logic                    drain_start,
    output logic [DATA_W-1:0]       shift_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic [CNT_W-1:0]        count,
    output logic                    empty,
    output logic                    full,
    output logic                    err
);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_err;

    logic [DATA_W-1:0] w_par_slot [DEPTH];
    logic [DATA_W-1:0] w_data_nxt [DEPTH];
    logic [DEPTH-1:0]  w_valid_nxt;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_busy;
    logic              w_idx_bad;
    logic              w_do_shift;
    logic              w_err_nxt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_par_slot
        assign w_par_slot[k] = par_data[k*DATA_W +: DATA_W];
    end

    assign w_busy     = (r_state == DRAIN);
    assign w_idx_bad  = load && (int'(load_idx) >= DEPTH);
    assign w_do_shift = w_busy || shift;
    assign w_err_nxt  = w_idx_bad || (w_busy && (load || par_load || drain_start));

    // Parallel load wins outright; otherwise shift first, then single load.
    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        if (!w_busy && par_load) begin
            w_data_nxt  = w_par_slot;
            w_valid_nxt = '1;
        end else begin
            if (w_do_shift) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    w_data_nxt[k] = r_data[k-1];
                end
                w_data_nxt[0] = '0;
                w_valid_nxt   = {r_valid[DEPTH-2:0], 1'b0};
            end
            if (!w_busy && load && !w_idx_bad) begin
                w_data_nxt[load_idx]  = load_data;
                w_valid_nxt[load_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (drain_start && !r_empty) w_state_nxt = DRAIN;
            DRAIN:   if (w_valid_nxt == '0)       w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    valid_popcount #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_valid_popcount (
        .valid (w_valid_nxt),
        .count (w_count_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_err   <= w_err_nxt;
        end
    end

    assign shift_out = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign busy      = w_busy;
    assign count     = r_count;
    assign empty     = r_empty;
    assign full      = r_full;
    assign err       = r_err;

endmodule : skew_shift_buffer
`default_nettype wire

// File: tb/tb_skew_shift_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_shift_buffer
// Description : Self-checking bench for skew_shift_buffer (DEPTH=7, DATA_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_shift_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 7;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load;
    logic [IDX_W-1:0]        load_idx;
    logic [DATA_W-1:0]       load_data;
    logic                    par_load;
    logic [DEPTH*DATA_W-1:0] par_data;
    logic                    shift;
    logic                    drain_start;
    logic [DATA_W-1:0]       shift_out;
    logic                    out_valid;
    logic                    busy;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    full;
    logic                    err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    skew_shift_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_idx    (load_idx),
        .load_data   (load_data),
        .par_load    (par_load),
        .par_data    (par_data),
        .shift       (shift),
        .drain_start (drain_start),
        .shift_out   (shift_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .err         (err)
    );

    // Reference model: slot 0 is the input end, slot DEPTH-1 the output end.
    logic [DATA_W-1:0] m_data  [DEPTH];
    bit                m_valid [DEPTH];
    bit                m_busy;
    bit                m_err;

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(m_valid[k]);
        return n;
    endfunction

    task automatic model_shift();
        for (int k = DEPTH - 1; k > 0; k--) begin
            m_data[k]  = m_data[k-1];
            m_valid[k] = m_valid[k-1];
        end
        m_data[0]  = '0;
        m_valid[0] = 1'b0;
    endtask

    task automatic model_step();
        int n_before;
        bit idx_bad;
        n_before = model_count();
        idx_bad  = load && (int'(load_idx) >= DEPTH);
        m_err    = idx_bad || (m_busy && (load || par_load || drain_start));
        if (m_busy) begin
            model_shift();
            if (model_count() == 0) m_busy = 1'b0;
        end else begin
            if (par_load) begin
                for (int k = 0; k < DEPTH; k++) begin
                    m_data[k]  = par_data[k*DATA_W +: DATA_W];
                    m_valid[k] = 1'b1;
                end
            end else begin
                if (shift) model_shift();
                if (load && !idx_bad) begin
                    m_data[load_idx]  = load_data;
                    m_valid[load_idx] = 1'b1;
                end
            end
            if (drain_start && n_before != 0) m_busy = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_data[k]  = '0;
                m_valid[k] = 1'b0;
            end
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_shift_out", 32'(shift_out), 32'(m_data[DEPTH-1]));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid[DEPTH-1]));
            chk("model_busy",      32'(busy),      32'(m_busy));
            chk("model_count",     32'(count),     32'(model_count()));
            chk("model_empty",     32'(empty),     32'(model_count() == 0));
            chk("model_full",      32'(full),      32'(model_count() == DEPTH));
            chk("model_err",       32'(err),       32'(m_err));
        end
    end

    initial begin
        rst         = 1'b1;
        load        = 1'b0;
        load_idx    = '0;
        load_data   = '0;
        par_load    = 1'b0;
        par_data    = '0;
        shift       = 1'b0;
        drain_start = 1'b0;
        #1;
        chk("rst_shift_out", 32'(shift_out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_count",     32'(count),     32'h0);
        chk("rst_empty",     32'(empty),     32'h1);
        chk("rst_full",      32'(full),      32'h0);
        chk("rst_err",       32'(err),       32'h0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Skew latency: slot 6 shows next cycle, slot 0 after six shifts
        load = 1'b1; load_idx = 3'd0; load_data = 8'hA1;
        @(negedge clk);
        load_idx = 3'd6; load_data = 8'hB2;
        @(negedge clk);
        load = 1'b0;
        chk("skew_b2_out",   32'(shift_out), 32'hB2);
        chk("skew_b2_valid", 32'(out_valid), 32'h1);
        chk("skew_count0",   32'(count),     32'd2);
        shift = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("skew_count", 32'(count), (k < 7) ? 32'd1 : 32'd0);
            if (k == 6) chk("skew_a1_out", 32'(shift_out), 32'hA1);
        end
        shift = 1'b0;

        // Simultaneous shift and load into the output slot
        load = 1'b1; load_idx = 3'd5; load_data = 8'h11;
        @(negedge clk);
        load_idx = 3'd6; load_data = 8'h22;
        @(negedge clk);
        shift = 1'b1; load_idx = 3'd6; load_data = 8'h33;
        @(negedge clk);
        shift = 1'b0; load = 1'b0;
        chk("ldsh_out",   32'(shift_out), 32'h33);
        chk("ldsh_count", 32'(count),     32'd1);

        // Parallel load then drain, with dropped requests mid-drain
        for (int k = 0; k < DEPTH; k++) par_data[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        par_load = 1'b1;
        @(negedge clk);
        par_load = 1'b0;
        chk("par_full",  32'(full),      32'h1);
        chk("par_count", 32'(count),     32'd7);
        chk("par_out",   32'(shift_out), 32'h07);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("drain_busy",  32'(busy),      32'h1);
            chk("drain_out",   32'(shift_out), 32'(7 - i));
            chk("drain_count", 32'(count),     32'(7 - i));
            if (i == 1) chk("drain_err_pulse", 32'(err), 32'h1);
            if (i == 2) chk("drain_err_clear", 32'(err), 32'h0);
            if (i == 0) begin
                load = 1'b1; load_idx = 3'd2; load_data = 8'h55; drain_start = 1'b1;
            end else begin
                load = 1'b0; drain_start = 1'b0;
            end
            @(negedge clk);
        end
        chk("drain_done_busy",  32'(busy),  32'h0);
        chk("drain_done_empty", 32'(empty), 32'h1);

        // Out-of-range index in IDLE
        load = 1'b1; load_idx = 3'd3; load_data = 8'h44;
        @(negedge clk);
        load_idx = 3'd7;
        @(negedge clk);
        load = 1'b0;
        chk("badidx_err",   32'(err),   32'h1);
        chk("badidx_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("badidx_err_clear", 32'(err), 32'h0);

        // Asynchronous reset in the middle of a drain
        par_load = 1'b1;
        @(negedge clk);
        par_load = 1'b0; drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy",      32'(busy),      32'h0);
        chk("mid_rst_count",     32'(count),     32'h0);
        chk("mid_rst_shift_out", 32'(shift_out), 32'h0);
        chk("mid_rst_empty",     32'(empty),     32'h1);
        @(negedge clk);
        rst = 1'b0; drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        chk("empty_drain_busy", 32'(busy),  32'h0);
        chk("empty_drain_err",  32'(err),   32'h0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            load        = ($urandom_range(0, 99) < 35);
            load_idx    = IDX_W'($urandom_range(0, 7));
            load_data   = DATA_W'($urandom());
            par_load    = ($urandom_range(0, 99) < 5);
            par_data    = (DEPTH*DATA_W)'({$urandom(), $urandom()});
            shift       = ($urandom_range(0, 99) < 40);
            drain_start = ($urandom_range(0, 99) < 6);
            @(negedge clk);
        end
        load = 1'b0; par_load = 1'b0; shift = 1'b0; drain_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_skew_shift_buffer
`default_nettype wire
